// File: rtl/wb_bfm_pkg.sv
// wb_bfm_pkg: shared Wishbone cycle-type / burst-type constants and slave state encoding.
// Rev 1.0
`default_nettype none

package wb_bfm_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/wb_bfm_burst_adr.sv
// wb_bfm_burst_adr: next beat address (+4) with BTE wrap inside a 16/32/64-byte block.
// Rev 1.0
`default_nettype none

module wb_bfm_burst_adr
    import wb_bfm_pkg::*;
#(
    parameter int aw = 32
) (
    input  logic [aw-1:0] adr,
    input  logic [1:0]    bte,
    output logic [aw-1:0] next_adr
);

    logic [aw-1:0] inc_adr;

    assign inc_adr = adr + aw'(4);

    // Wrapped modes take only the in-block bits from the increment; the rest stay fixed.
    always_comb begin
        next_adr = inc_adr;
        case (bte)
            BTE_WRAP4:  next_adr = {adr[aw-1:4], inc_adr[3:2], adr[1:0]};
            BTE_WRAP8:  next_adr = {adr[aw-1:5], inc_adr[4:2], adr[1:0]};
            BTE_WRAP16: next_adr = {adr[aw-1:6], inc_adr[5:2], adr[1:0]};
            default:    next_adr = inc_adr;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/wb_bfm_mem.sv
// wb_bfm_mem: Wishbone B3 slave memory, classic and registered-feedback bursts (all BTE modes).
// Optional WB_BFM_MEM_ERR_EN: out-of-range beats answer with err instead of aliasing. Rev 1.0
`default_nettype none

module wb_bfm_mem
    import wb_bfm_pkg::*;
#(
    parameter int aw             = 32,
    parameter int dw             = 32,
    parameter int MEM_SIZE_BYTES = 32768
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [dw-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [dw-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o
);

    localparam int MEM_AW = $clog2(MEM_SIZE_BYTES);
    localparam int WORDS  = MEM_SIZE_BYTES / 4;

    logic [dw-1:0]     mem [0:WORDS-1];

    state_t            state;
    state_t            state_n;
    logic [aw-1:0]     burst_adr;
    logic [aw-1:0]     burst_adr_n;
    logic [aw-1:0]     beat_adr;
    logic [aw-1:0]     next_adr;
    logic [MEM_AW-3:0] idx;
    logic              req;
    logic              beat;
    logic              ack_n;
    logic              wr_en;

    assign req      = wb_cyc_i & wb_stb_i;
    assign beat_adr = (state == ST_BURST) ? burst_adr : wb_adr_i;
    assign idx      = beat_adr[MEM_AW-1:2];
    assign wb_rty_o = 1'b0;

    wb_bfm_burst_adr #(
        .aw (aw)
    ) u_burst_adr (
        .adr      (beat_adr),
        .bte      (wb_bte_i),
        .next_adr (next_adr)
    );

`ifdef WB_BFM_MEM_ERR_EN
    logic out_of_range;
    logic err_n;
    logic err;

    assign out_of_range = |beat_adr[aw-1:MEM_AW];
    assign wb_err_o     = err;
`else
    assign wb_err_o     = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        burst_adr_n = burst_adr;
        beat        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    beat        = 1'b1;
                    burst_adr_n = next_adr;
                    state_n     = (wb_cti_i == CTI_INC) ? ST_BURST : ST_ACK;
                end
            end
            ST_ACK: begin
                state_n = ST_IDLE;
            end
            ST_BURST: begin
                if (req) begin
                    beat        = 1'b1;
                    burst_adr_n = next_adr;
                    // Anything other than an incrementing beat closes the burst.
                    state_n     = (wb_cti_i == CTI_INC) ? ST_BURST : ST_ACK;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
`ifdef WB_BFM_MEM_ERR_EN
        ack_n = beat & ~out_of_range;
        err_n = beat & out_of_range;
        if (err_n) begin
            state_n = ST_IDLE;
        end
`else
        ack_n = beat;
`endif
    end

    // Gated by reset so a master still strobing during reset cannot write.
    assign wr_en = ack_n & wb_we_i & wb_rst_i;

    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            for (int n = 0; n < 4; n++) begin
                if (wb_sel_i[n]) begin
                    mem[idx][8*n +: 8] <= wb_dat_i[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state     <= ST_IDLE;
            burst_adr <= '0;
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
`ifdef WB_BFM_MEM_ERR_EN
            err       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            burst_adr <= burst_adr_n;
            wb_ack_o  <= ack_n;
`ifdef WB_BFM_MEM_ERR_EN
            err       <= err_n;
`endif
            if (ack_n && !wb_we_i) begin
                wb_dat_o <= mem[idx];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_bfm_mem.sv
// tb_wb_bfm_mem: randomized self-checking bench for wb_bfm_mem against a word-array reference model.
// Rev 1.0
`default_nettype none

module tb_wb_bfm_mem;

    localparam int MEM = 32768;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [int];
    logic [31:0] bw_dat [16];
    logic        br_ack [16];
    logic [31:0] br_dat [16];
    logic        b_tail;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_bfm_mem #(.aw(32), .dw(32), .MEM_SIZE_BYTES(MEM)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_cti_i (wb_cti_i),
        .wb_bte_i (wb_bte_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_rty_o (wb_rty_o)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int widx(input logic [31:0] a);
        return int'((a % MEM) >> 2);
    endfunction

    // Wrapping block is 16/32/64 bytes for BTE 1/2/3; linear otherwise.
    function automatic logic [31:0] nxt(input logic [31:0] a, input logic [1:0] bte);
        logic [31:0] blk;
        if (bte == 2'd0) return a + 32'd4;
        blk = 32'd8 << bte;
        return (a & ~(blk - 32'd1)) | ((a + 32'd4) & (blk - 32'd1));
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (ref_mem.exists(widx(a))) return ref_mem[widx(a)];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] w;
        w = model_rd(a);
        for (int n = 0; n < 4; n++) if (sel[n]) w[8*n +: 8] = d[8*n +: 8];
        ref_mem[widx(a)] = w;
    endtask

    task automatic bus_idle();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = 4'h0;
        wb_adr_i = '0;   wb_dat_i = '0;   wb_cti_i = 3'b000; wb_bte_i = 2'b00;
    endtask

    // Classic single access; returns ack/err on the response edge and on the following edge.
    task automatic classic(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] sel, output logic ack1, output logic err1,
                           output logic ack2, output logic err2, output logic [31:0] rdat);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = a;
        wb_dat_i = d;    wb_sel_i = sel;  wb_cti_i = 3'b000; wb_bte_i = 2'b00;
        @(posedge wb_clk_i); #1;
        ack1 = wb_ack_o; err1 = wb_err_o; rdat = wb_dat_o;
        bus_idle();
        @(posedge wb_clk_i); #1;
        ack2 = wb_ack_o; err2 = wb_err_o;
    endtask

    // Master presents beat k during cycle k and samples the response just after edge k.
    task automatic run_burst(input logic we, input logic [31:0] start, input logic [1:0] bte, input int n);
        logic [31:0] a;
        a = start;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_sel_i = 4'hF; wb_bte_i = bte;
        for (int k = 0; k < n; k++) begin
            wb_adr_i = a; wb_dat_i = bw_dat[k];
            wb_cti_i = (k == n - 1) ? 3'b111 : 3'b010;
            @(posedge wb_clk_i); #1;
            br_ack[k] = wb_ack_o; br_dat[k] = wb_dat_o;
            if (we) model_wr(a, bw_dat[k], 4'hF);
            a = nxt(a, bte);
        end
        bus_idle();
        @(posedge wb_clk_i); #1;
        b_tail = wb_ack_o;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b0;
        bus_idle();
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hF; wb_adr_i = 32'h40;
        repeat (3) @(posedge wb_clk_i);
        #1;
        checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", wb_ack_o); end
        checks++; if (wb_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", wb_err_o); end
        checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", wb_dat_o); end
        checks++; if (wb_rty_o !== 1'b0) begin errors++; $display("FAIL reset_rty: got %b want 0", wb_rty_o); end
        bus_idle();
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
    endtask

    task automatic test_classic();
        logic a1, e1, a2, e2;
        logic [31:0] rd;
        classic(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, a1, e1, a2, e2, rd);
        model_wr(32'h100, 32'hDEADBEEF, 4'hF);
        checks++; if (a1 !== 1'b1 || e1 !== 1'b0) begin errors++; $display("FAIL classic_wr_ack: got ack=%b err=%b want ack=1 err=0", a1, e1); end
        checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL classic_wr_gap: got ack=%b want 0", a2); end
        classic(1'b0, 32'h100, 32'h0, 4'hF, a1, e1, a2, e2, rd);
        checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL classic_rd_ack: got %b want 1", a1); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL classic_rd_dat: got %h want deadbeef", rd); end
        checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL classic_rd_gap: got ack=%b want 0", a2); end
    endtask

    task automatic test_byte_lanes();
        logic a1, e1, a2, e2;
        logic [31:0] rd, ad, d;
        logic [3:0] sel;
        classic(1'b1, 32'h200, 32'h11223344, 4'hF, a1, e1, a2, e2, rd);
        model_wr(32'h200, 32'h11223344, 4'hF);
        classic(1'b1, 32'h200, 32'hAABBCCDD, 4'b0101, a1, e1, a2, e2, rd);
        model_wr(32'h200, 32'hAABBCCDD, 4'b0101);
        classic(1'b0, 32'h200, 32'h0, 4'b0001, a1, e1, a2, e2, rd);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL lanes_fixed: got %h want 11bb33dd", rd); end
        for (int i = 0; i < 10; i++) begin
            ad  = 32'h2000 + ($urandom_range(0, 15) << 2);
            d   = $urandom;
            sel = ref_mem.exists(widx(ad)) ? 4'($urandom_range(0, 15)) : 4'hF;
            classic(1'b1, ad, d, sel, a1, e1, a2, e2, rd);
            model_wr(ad, d, sel);
            classic(1'b0, ad, 32'h0, 4'($urandom_range(0, 15)), a1, e1, a2, e2, rd);
            checks++; if (a1 !== 1'b1 || rd !== model_rd(ad)) begin
                errors++; $display("FAIL lanes_rand[%0d]: adr=%h got ack=%b dat=%h want ack=1 dat=%h", i, ad, a1, rd, model_rd(ad));
            end
        end
    endtask

    task automatic test_linear_burst();
        for (int k = 0; k < 8; k++) bw_dat[k] = 32'(k);
        run_burst(1'b1, 32'h300, 2'b00, 8);
        for (int k = 0; k < 8; k++) begin
            checks++; if (br_ack[k] !== 1'b1) begin errors++; $display("FAIL lin_wr_ack[%0d]: got %b want 1", k, br_ack[k]); end
        end
        checks++; if (b_tail !== 1'b0) begin errors++; $display("FAIL lin_wr_tail: got %b want 0", b_tail); end
        run_burst(1'b0, 32'h300, 2'b00, 8);
        for (int k = 0; k < 8; k++) begin
            checks++; if (br_ack[k] !== 1'b1 || br_dat[k] !== 32'(k)) begin
                errors++; $display("FAIL lin_rd[%0d]: got ack=%b dat=%h want ack=1 dat=%h", k, br_ack[k], br_dat[k], 32'(k));
            end
        end
        checks++; if (b_tail !== 1'b0) begin errors++; $display("FAIL lin_rd_tail: got %b want 0", b_tail); end
    endtask

    task automatic test_wrap_burst();
        logic [31:0] exp4 [4];
        logic [31:0] a, st;
        logic [1:0]  bte;
        int          n;
        exp4[0] = 32'd2; exp4[1] = 32'd3; exp4[2] = 32'd0; exp4[3] = 32'd1;
        run_burst(1'b0, 32'h308, 2'b01, 4);
        for (int k = 0; k < 4; k++) begin
            checks++; if (br_ack[k] !== 1'b1 || br_dat[k] !== exp4[k]) begin
                errors++; $display("FAIL wrap4_fixed[%0d]: got ack=%b dat=%h want ack=1 dat=%h", k, br_ack[k], br_dat[k], exp4[k]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            bte = 2'($urandom_range(0, 3));
            n   = $urandom_range(2, 12);
            st  = 32'h1000 + ($urandom_range(0, 255) << 2);
            for (int k = 0; k < 16; k++) bw_dat[k] = $urandom;
            run_burst(1'b1, st, bte, n);
            run_burst(1'b0, st, bte, n);
            a = st;
            for (int k = 0; k < n; k++) begin
                checks++; if (br_ack[k] !== 1'b1 || br_dat[k] !== model_rd(a)) begin
                    errors++; $display("FAIL burst_rand[%0d.%0d]: bte=%0d adr=%h got ack=%b dat=%h want ack=1 dat=%h",
                                       i, k, bte, a, br_ack[k], br_dat[k], model_rd(a));
                end
                a = nxt(a, bte);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic a1, e1, a2, e2;
        logic [31:0] rd, ad;
        for (int k = 0; k < 8; k++) bw_dat[k] = 32'hA000_0000 + 32'(k);
        run_burst(1'b1, 32'h400, 2'b00, 8);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hF;
        wb_cti_i = 3'b010; wb_bte_i = 2'b00;
        for (int k = 0; k < 3; k++) begin
            wb_adr_i = 32'h400 + 32'(4 * k); wb_dat_i = 32'hB000_0000 + 32'(k);
            @(posedge wb_clk_i); #1;
            model_wr(wb_adr_i, wb_dat_i, 4'hF);
        end
        wb_adr_i = 32'h40C; wb_dat_i = 32'hB000_0003;
        wb_rst_i = 1'b0;
        #1;
        checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL midrst_ack_now: got %b want 0", wb_ack_o); end
        for (int k = 3; k < 5; k++) begin
            wb_adr_i = 32'h400 + 32'(4 * k); wb_dat_i = 32'hB000_0000 + 32'(k);
            @(posedge wb_clk_i); #1;
            checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL midrst_ack_held[%0d]: got %b want 0", k, wb_ack_o); end
        end
        bus_idle();
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        for (int k = 0; k < 8; k++) begin
            ad = 32'h400 + 32'(4 * k);
            classic(1'b0, ad, 32'h0, 4'hF, a1, e1, a2, e2, rd);
            checks++; if (rd !== model_rd(ad)) begin
                errors++; $display("FAIL midrst_mem[%0d]: got %h want %h", k, rd, model_rd(ad));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ack_seq [4];
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h100;
        wb_sel_i = 4'hF; wb_cti_i = 3'b000; wb_bte_i = 2'b00;
        for (int k = 0; k < 4; k++) begin
            @(posedge wb_clk_i); #1;
            ack_seq[k] = wb_ack_o;
        end
        bus_idle();
        @(posedge wb_clk_i); #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (ack_seq[k] !== ((k % 2) == 0)) begin
                errors++; $display("FAIL b2b_ack[%0d]: got %b want %b", k, ack_seq[k], (k % 2) == 0);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic a1, e1, a2, e2;
        logic [31:0] rd, v0;
        v0 = $urandom;
        classic(1'b1, 32'h0, v0, 4'hF, a1, e1, a2, e2, rd);
        model_wr(32'h0, v0, 4'hF);
        classic(1'b0, 32'h100, 32'h0, 4'hF, a1, e1, a2, e2, rd);
        classic(1'b0, 32'h8000, 32'h0, 4'hF, a1, e1, a2, e2, rd);
`ifdef WB_BFM_MEM_ERR_EN
        checks++; if (a1 !== 1'b0 || e1 !== 1'b1) begin errors++; $display("FAIL oor_err: got ack=%b err=%b want ack=0 err=1", a1, e1); end
        checks++; if (rd !== model_rd(32'h100)) begin errors++; $display("FAIL oor_dat_hold: got %h want %h", rd, model_rd(32'h100)); end
        checks++; if (e2 !== 1'b0 || a2 !== 1'b0) begin errors++; $display("FAIL oor_err_len: got ack=%b err=%b want 0 0", a2, e2); end
`else
        checks++; if (a1 !== 1'b1 || e1 !== 1'b0) begin errors++; $display("FAIL oor_alias_ack: got ack=%b err=%b want ack=1 err=0", a1, e1); end
        checks++; if (rd !== v0) begin errors++; $display("FAIL oor_alias_dat: got %h want %h", rd, v0); end
        checks++; if (e2 !== 1'b0) begin errors++; $display("FAIL oor_alias_err: got %b want 0", e2); end
`endif
    endtask

    initial begin
        bus_idle();
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;
        test_reset();
        test_classic();
        test_byte_lanes();
        test_linear_burst();
        test_wrap_burst();
        test_back_to_back();
        test_reset_mid_burst();
        test_out_of_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_bfm_mem.md
# wb_bfm_mem

Synthesizable Wishbone B3 slave memory used as the target model in the Wishbone BFM test environment. A bus master, normally the Wishbone transactor, drives it directly. It stores data in a byte-addressable word array with per-lane byte enables. It supports classic single cycles and registered-feedback incrementing bursts with all four BTE wrap modes.

## Interface
- `aw`, 32: address width in bits.
- `dw`, 32: data width in bits; must be 32 (4 byte lanes).
- `MEM_SIZE_BYTES`, 32768: memory size in bytes; power of two, ≥16×(dw/8).
- `wb_clk_i`  in  1: clock, rising edge.
- `wb_rst_i`  in  1: reset, asynchronous, active-low.
- `wb_adr_i`  in  aw: byte address; bits [1:0] ignored.
- `wb_dat_i`  in  dw: write data.
- `wb_sel_i`  in  4: byte-lane enables; bit n maps to byte n of the word.
- `wb_we_i`  in  1: write enable.
- `wb_cyc_i`  in  1: cycle valid.
- `wb_stb_i`  in  1: strobe.
- `wb_cti_i`  in  3: cycle type identifier.
- `wb_bte_i`  in  2: burst type extension.
- `wb_dat_o`  out  dw: read data, registered.
- `wb_ack_o`  out  1: acknowledge, registered.
- `wb_err_o`  out  1: error, registered.
- `wb_rty_o`  out  1: retry; always 0.

## Operation
- A request exists when `wb_cyc_i & wb_stb_i` is high.
- CTI 000 (classic) or 111 (end-of-burst) is a single access. CTI 010 (incrementing) is a burst beat. Any other CTI value is treated as classic.
- Word index is `adr[log2(MEM_SIZE_BYTES)-1:2]`.
- Write:
  - On each edge that asserts ack for a write beat, each lane with `wb_sel_i[n]=1` stores `wb_dat_i[8n+7:8n]`.
  - Lanes with `sel=0` are unchanged.
- Read:
  - `wb_dat_o` presents the full word at the beat address, regardless of `wb_sel_i`.
  - `wb_dat_o` holds its last value when no read beat is acknowledged.
- State machine:
  - **IDLE**
    - On a classic request: go to **ACK**, ack=1, and read/write at `wb_adr_i`.
    - On a CTI=010 request: go to **BURST**, ack=1, first beat at `wb_adr_i`, and internal address = next(`wb_adr_i`).
  - **ACK**: ack=0; always return to **IDLE**. This gives a mandatory one-cycle gap.
  - **BURST**
    - While the request holds with CTI=010: ack stays 1 and the beat uses the internal address. The internal address then advances to next(address).
    - On CTI=111: perform the final beat, then go to **ACK**.
    - If cyc or stb drops: ack=0, go to **IDLE**, and no access is performed.
- next(a) adds 4. Wrap uses BTE:
  - 00: linear.
  - 01: wrap within 16-byte block (a[3:2] wraps).
  - 10: wrap within 32-byte block (a[4:2] wraps).
  - 11: wrap within 64-byte block (a[5:2] wraps).
  - Upper bits are unchanged.
- Linear wrap past the top of memory wraps modulo `MEM_SIZE_BYTES`.
- `wb_rty_o` is tied to 0.

## Timing
- Reset (while `wb_rst_i`=0, immediate): ack=0, err=0, `wb_dat_o`=0, state **IDLE**. Memory contents are not cleared and are undefined until written.
- Reset asserted mid-burst aborts the burst; no further writes occur.
- Classic access: ack rises on the edge after the request is sampled and lasts exactly one cycle. The next classic access can be acknowledged no earlier than 2 cycles later.
- Burst of N beats: ack stays high for N consecutive cycles, and read data is valid in every ack cycle.
- Ack and err are never high together.

## Configuration
- `WB_BFM_MEM_ERR_EN` defined:
  - Any beat whose address bits at or above log2(`MEM_SIZE_BYTES`) are non-zero responds with err for one cycle instead of ack.
  - That beat does no write, leaves `wb_dat_o` unchanged, and returns the state to **IDLE**.
  - A burst that crosses the memory end also takes this path.
- `WB_BFM_MEM_ERR_EN` undefined: `wb_err_o`=0 and out-of-range addresses alias modulo size.

## Structure
- Package `wb_bfm_pkg` holds:
  - CTI constants `CTI_CLASSIC`=000, `CTI_INC`=010, `CTI_EOB`=111.
  - BTE constants `BTE_LINEAR`/`BTE_WRAP4`/`BTE_WRAP8`/`BTE_WRAP16`.
  - The state enum.
- One sub-module, `wb_bfm_burst_adr`: combinational next-address calculation from address and BTE.

## Test plan
- After reset release: write 0xDEADBEEF to 0x100 (sel=1111), then read 0x100 → 0xDEADBEEF. Ack is one cycle each time, with a gap cycle between.
- Write 0x11223344 to 0x200, then write 0xAABBCCDD with sel=0101, then read → 0x11BB33DD.
- Linear burst write of 0,1,2,…,7 at 0x300, then linear burst read → 8 consecutive ack cycles returning 0..7.
- BTE=01 burst read starting at 0x308, 4 beats → addresses 0x308, 0x30C, 0x300, 0x304 → data 2,3,0,1.
- Reset asserted mid-burst: ack drops in the same cycle; subsequent reads of the burst's remaining addresses show no write.
- With `WB_BFM_MEM_ERR_EN` and default size: read 0x8000 → err for one cycle, ack=0. Without the macro, the same read returns the word at 0x0000.
